dram_win_reader: RTL and testbench
==================================

Name: dram_win_reader

Overview:
- Read-side initiator for the original-image DRAM (registered 7x7 window read, 392-bit rdata, rdata forced to zero on any cycle without ren).
- Raster-scans every valid KxK window position of an IMG_W x IMG_H frame and drives mem_ren/mem_raddr.
- Captures each returned window exactly one cycle after the memory samples the read.
- Delivers windows to the downstream filter over a valid/ready stream, with a small FIFO that absorbs backpressure without losing data.

Parameters:
- D_WIDTH, 8, pixel width in bits
- A_WIDTH, 21, memory address width
- IMG_W, 1280, frame width in pixels (row stride in memory)
- IMG_H, 720, frame height in pixels
- K, 7, window size; MASKLEN = K*K*D_WIDTH = 392
- ROW_W, 10, width of the window row coordinate
- COL_W, 11, width of the window column coordinate
- FIFO_DEPTH, 4, output FIFO entries; minimum 3

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse that begins a frame scan
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last window is popped
- mem_ren  out  1  registered read enable to the DRAM
- mem_raddr  out  A_WIDTH  registered top-left address of the window
- mem_rdata  in  MASKLEN  window data from the DRAM
- win_valid  out  1  FIFO head is valid
- win_ready  in  1  downstream accepts the head
- win_data  out  MASKLEN  FIFO head window, byte order unchanged from mem_rdata
- win_row  out  ROW_W  top-left row of the head window
- win_col  out  COL_W  top-left column of the head window
- win_last  out  1  head is the final window of the frame

Behaviour:
- Reset, applied at any time including mid-frame:
  - state = IDLE; all counters, FIFO pointers and in-flight flags cleared.
  - mem_ren=0, mem_raddr=0, busy=0, done=0, win_valid=0.
  - win_data, win_row, win_col and win_last are all 0.
  - In-flight reads are discarded; mem_rdata arriving after reset is never captured.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE: start=1 → RUN; row=col=0, row_base=0. start is ignored in every other state.
  - RUN: issues reads. After issuing the read for (row=IMG_H-K, col=IMG_W-K) → DRAIN.
  - DRAIN: no new reads. When the FIFO is empty and nothing is in flight → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
  - busy = (state != IDLE).
- Address generation:
  - mem_raddr = row_base + col. No multiplier.
  - When col == IMG_W-K: col←0, row←row+1, row_base←row_base+IMG_W. Otherwise col←col+1.
  - Windows per frame = (IMG_W-K+1)*(IMG_H-K+1).
- Read pipeline:
  - mem_ren is set at an edge; the DRAM samples it at the next edge; mem_rdata is valid during the following cycle.
  - cap_q is a registered copy of mem_ren. At every edge where cap_q=1, {mem_rdata, row, col, last} for that read is written into the FIFO.
  - Coordinates and the last flag travel in a 2-stage side pipeline aligned with cap_q.
- Issue rule:
  - pop = win_valid & win_ready.
  - inflight = mem_ren + cap_q, range 0..2.
  - In RUN, mem_ren for the next cycle = 1 iff (fifo_count + inflight − pop) < FIFO_DEPTH.
  - In all other states mem_ren goes to 0 the cycle after leaving RUN.
  - With win_ready held high this sustains one window per clock.
- Latency:
  - start sampled at edge E0 → mem_ren=1, mem_raddr=0 after E0.
  - FIFO write at E2; win_valid=1 in the cycle after E2.
- FIFO rules:
  - Head outputs are stable while win_valid=1 and win_ready=0.
  - Simultaneous push and pop keeps fifo_count unchanged.
  - Overflow is impossible by the issue rule; an overflow assertion fires in simulation if it occurs.
  - Windows exit in strict raster order.
- win_last=1 only with the window at (IMG_H-K, IMG_W-K). done follows the pop of that window by at most 2 cycles.

Test Plan:
1. Reset check: assert rst mid-RUN for 1 cycle → next cycle mem_ren=0, win_valid=0, busy=0. The following start restarts at mem_raddr=0 and no stale window appears.
2. Small frame, steady flow: IMG_W=16, IMG_H=12, memory[i]=i[7:0], win_ready=1.
   - First win_valid 2 cycles after start.
   - Exactly 60 windows, one per clock.
   - Window 10 has row=1, col=0, raddr=16.
   - Last window: row=5, col=9, raddr=89, win_last=1; done pulses once.
3. Data check: window (0,0) win_data bytes MSB-first = 0..6, 16..22, …, 96..102. The scoreboard compares every window against a reference model.
4. Backpressure: drop win_ready for 10 cycles after the first valid.
   - mem_ren stops with ≤FIFO_DEPTH outstanding.
   - Head win_data/row/col are held stable.
   - No windows lost or duplicated after release.
5. Random win_ready at 50%, 3 back-to-back frames: all 180 windows in order. A start pulse while busy is ignored (frame count unchanged).
6. Full size (1280x720, img21 contents): 909,636 windows; last raddr = 913,913; done asserted once.

Source files
------------

// File: rtl/dram_win_reader.sv
// dram_win_reader: raster-scans every KxK window of a frame, issues registered
// reads to the image DRAM, captures each returned window one cycle after the
// DRAM samples the read, and streams windows downstream through a small FIFO.
module dram_win_reader #(
  parameter int D_WIDTH    = 8,
  parameter int A_WIDTH    = 21,
  parameter int IMG_W      = 1280,
  parameter int IMG_H      = 720,
  parameter int K          = 7,
  parameter int ROW_W      = 10,
  parameter int COL_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_ren,
  output logic [A_WIDTH-1:0]        mem_raddr,
  input  logic [K*K*D_WIDTH-1:0]    mem_rdata,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [K*K*D_WIDTH-1:0]    win_data,
  output logic [ROW_W-1:0]          win_row,
  output logic [COL_W-1:0]          win_col,
  output logic                      win_last
);

  localparam int MASKLEN  = K * K * D_WIDTH;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int PROJ_W   = CNT_W + 2;
  localparam int COL_LAST = IMG_W - K;
  localparam int ROW_LAST = IMG_H - K;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  state_t               state_nx;

  // Scan position of the next window to request.
  logic [ROW_W-1:0]     row;
  logic [COL_W-1:0]     col;
  logic [A_WIDTH-1:0]   row_base;
  logic                 at_last;

  // Side pipeline: p0 aligned with mem_ren, p1 aligned with the capture stage.
  logic [ROW_W-1:0]     row_p0;
  logic [COL_W-1:0]     col_p0;
  logic                 last_p0;
  logic [ROW_W-1:0]     row_p1;
  logic [COL_W-1:0]     col_p1;
  logic                 last_p1;
  logic                 vld_p1;

  // Output FIFO.
  logic [MASKLEN-1:0]   data_mem [FIFO_DEPTH];
  logic [ROW_W-1:0]     row_mem  [FIFO_DEPTH];
  logic [COL_W-1:0]     col_mem  [FIFO_DEPTH];
  logic                 last_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;

  logic                 push;
  logic                 pop;
  logic                 issue;
  logic [PROJ_W-1:0]    projected;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign at_last = (row == ROW_W'(ROW_LAST)) && (col == COL_W'(COL_LAST));
  assign push    = vld_p1;
  assign pop     = win_valid & win_ready;

  // Issue decision: a read is allowed only if every window already owed a slot still fits.
  always_comb begin
    projected = PROJ_W'(fifo_cnt) + PROJ_W'(mem_ren) + PROJ_W'(vld_p1) - PROJ_W'(pop);
    issue     = ((state == RUN) || ((state == IDLE) && start)) &&
                (projected < PROJ_W'(FIFO_DEPTH));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (issue) state_nx = at_last ? DRAIN : RUN;
      RUN:     if (issue && at_last) state_nx = DRAIN;
      DRAIN:   if ((fifo_cnt == '0) && !mem_ren && !vld_p1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Stage p0: read request and raster counters (address = row_base + col).
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      row       <= '0;
      col       <= '0;
      row_base  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      mem_ren <= issue;
      vld_p1  <= mem_ren;
      if (issue) begin
        mem_raddr <= row_base + A_WIDTH'(col);
        if (col == COL_W'(COL_LAST)) begin
          col      <= '0;
          row      <= row + ROW_W'(1);
          row_base <= row_base + A_WIDTH'(IMG_W);
        end else begin
          col <= col + COL_W'(1);
        end
      end else if (state == DONE) begin
        row      <= '0;
        col      <= '0;
        row_base <= '0;
      end
    end
  end

  // Stage p0 -> p1: coordinates follow their read through the DRAM latency.
  always_ff @(posedge clk) begin
    if (issue) begin
      row_p0  <= row;
      col_p0  <= col;
      last_p0 <= at_last;
    end
    row_p1  <= row_p0;
    col_p1  <= col_p0;
    last_p1 <= last_p0;
  end

  // Stage p1 -> FIFO: capture returned window with its coordinates.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      row_mem[wr_ptr]  <= row_p1;
      col_mem[wr_ptr]  <= col_p1;
      last_mem[wr_ptr] <= last_p1;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Head outputs, forced to zero while the FIFO is empty.
  always_comb begin
    win_valid = (fifo_cnt != '0);
    win_data  = '0;
    win_row   = '0;
    win_col   = '0;
    win_last  = 1'b0;
    if (win_valid) begin
      win_data = data_mem[rd_ptr];
      win_row  = row_mem[rd_ptr];
      win_col  = col_mem[rd_ptr];
      win_last = last_mem[rd_ptr];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_cnt == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_dram_win_reader.sv
// Bench for dram_win_reader on a 16x12 frame with a byte-addressed DRAM model.
module tb_dram_win_reader;

  localparam int DW = 8;
  localparam int AW = 21;
  localparam int IW = 16;
  localparam int IH = 12;
  localparam int KK = 7;
  localparam int RW = 10;
  localparam int CW = 11;
  localparam int FD = 4;
  localparam int ML = KK * KK * DW;
  localparam int NC = IW - KK + 1;
  localparam int NR = IH - KK + 1;
  localparam int NW = NC * NR;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [ML-1:0] mem_rdata;
  logic          win_valid;
  logic          win_ready;
  logic [ML-1:0] win_data;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          win_last;

  dram_win_reader #(
    .D_WIDTH(DW), .A_WIDTH(AW), .IMG_W(IW), .IMG_H(IH), .K(KK),
    .ROW_W(RW), .COL_W(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col), .win_last(win_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window contents for top-left address a: memory[i] = i[7:0], first pixel in the MSB byte.
  function automatic logic [ML-1:0] win_of(input int a);
    logic [ML-1:0] v;
    v = '0;
    for (int r = 0; r < KK; r++)
      for (int c = 0; c < KK; c++)
        v = {v[ML-9:0], 8'(a + r * IW + c)};
    return v;
  endfunction

  // DRAM model: samples ren/addr at an edge, returns data during the following cycle.
  logic          rd_v;
  logic [AW-1:0] rd_a;
  initial begin rd_v = 1'b0; rd_a = '0; end
  always @(posedge clk) begin
    rd_v <= mem_ren;
    rd_a <= mem_raddr;
  end
  assign mem_rdata = rd_v ? win_of(int'(rd_a)) : '0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [ML-1:0] act, input logic [ML-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard state.
  int            cyc = 0;
  int            iss_n = 0;
  int            pop_n = 0;
  int            outst = 0;
  int            last_pop_cyc = 0;
  int            done_cnt = 0;
  int            pops_total = 0;
  int            iss_total = 0;
  bit            held = 0;
  bit            final_popped = 0;
  logic [ML-1:0] prev_data;
  logic [RW-1:0] prev_row;
  logic [CW-1:0] prev_col;
  logic [ML-1:0] w00_lit;

  initial w00_lit = 392'h00010203040506_10111213141516_20212223242526_30313233343536_40414243444546_50515253545556_60616263646566;

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      iss_n = 0; pop_n = 0; outst = 0; held = 0; final_popped = 0;
    end else begin
      if (held) begin
        chk("hold_valid", win_valid, 1);
        chkw("hold_data", win_data, prev_data);
        chk("hold_row", win_row, prev_row);
        chk("hold_col", win_col, prev_col);
      end
      if (mem_ren) begin
        chk("raddr", mem_raddr, (iss_n / NC) * IW + iss_n % NC);
        if (iss_n == 10)     chk("raddr_w10_lit", mem_raddr, 16);
        if (iss_n == NW - 1) chk("raddr_last_lit", mem_raddr, 89);
        iss_n = (iss_n + 1) % NW;
        outst++;
        iss_total++;
        chk("outstanding_le_depth", outst <= FD, 1);
      end
      if (win_valid && win_ready) begin
        chk("win_row", win_row, pop_n / NC);
        chk("win_col", win_col, pop_n % NC);
        chk("win_last", win_last, pop_n == NW - 1);
        chkw("win_data", win_data, win_of((pop_n / NC) * IW + pop_n % NC));
        if (pop_n == 0)  chkw("win00_data_lit", win_data, w00_lit);
        if (pop_n == 10) begin chk("w10_row_lit", win_row, 1); chk("w10_col_lit", win_col, 0); end
        if (pop_n == NW - 1) begin chk("wl_row_lit", win_row, 5); chk("wl_col_lit", win_col, 9); end
        final_popped = (pop_n == NW - 1);
        pop_n = (pop_n + 1) % NW;
        outst--;
        pops_total++;
        last_pop_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last", final_popped, 1);
        chk("done_latency", (cyc - last_pop_cyc) <= 2, 1);
        final_popped = 0;
      end
      held      = win_valid && !win_ready;
      prev_data = win_data;
      prev_row  = win_row;
      prev_col  = win_col;
    end
  end

  task automatic wait_done(input int max, input bit rnd);
    int n;
    bit got;
    n = 0;
    got = 0;
    while (n < max && !got) begin
      @(posedge clk); #1;
      if (rnd) win_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    int n;
    int p0;
    int d0;
    int i0;
    rst = 1'b1; start = 1'b0; win_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_raddr", mem_raddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", win_valid, 0);
    chkw("rst_data", win_data, '0);
    chk("rst_row", win_row, 0);
    chk("rst_col", win_col, 0);
    chk("rst_last", win_last, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset in the middle of a scan.
    win_ready = 1'b1;
    pulse_start();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_mem_ren", mem_ren, 0);
    chk("midrst_valid", win_valid, 0);
    chk("midrst_busy", busy, 0);
    chkw("midrst_data", win_data, '0);
    repeat (3) @(posedge clk);

    // Steady flow with latency checks.
    #1;
    p0 = pops_total; d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("lat_ren_e0", mem_ren, 1);
    chk("lat_raddr_e0", mem_raddr, 0);
    chk("lat_busy_e0", busy, 1);
    chk("lat_valid_e0", win_valid, 0);
    @(negedge clk);
    chk("lat_valid_e1", win_valid, 0);
    @(negedge clk);
    chk("lat_valid_e2", win_valid, 1);
    n = 0;
    while (!(win_valid && win_last) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stream_span", n, NW - 1);
    wait_done(100, 0);
    @(posedge clk); #1;
    chk("flow_pops", pops_total - p0, NW);
    chk("flow_done_cnt", done_cnt - d0, 1);

    // Backpressure.
    p0 = pops_total;
    pulse_start();
    n = 0;
    while (!win_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_first_valid", win_valid, 1);
    @(posedge clk); #1 win_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("bp_ren_stopped", mem_ren, 0);
    chk("bp_valid_held", win_valid, 1);
    @(posedge clk); #1 win_ready = 1'b1;
    wait_done(300, 0);
    @(posedge clk); #1;
    chk("bp_pops", pops_total - p0, NW);

    // Three frames with random ready and a start pulse while busy.
    p0 = pops_total; d0 = done_cnt;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      if (f == 1) begin
        repeat (15) begin
          @(posedge clk); #1 win_ready = 1'($urandom_range(0, 1));
        end
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done(2000, 1);
    end
    @(posedge clk); #1;
    win_ready = 1'b1;
    i0 = iss_total;
    chk("rnd_pops", pops_total - p0, 3 * NW);
    chk("rnd_frames", done_cnt - d0, 3);
    repeat (6) @(posedge clk);
    #1;
    chk("idle_no_issue", iss_total - i0, 0);
    chk("idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
